// File: rtl/clock_pkg.sv
// Shared encodings for the clock time-setting controller.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_SET_SEC  = 2'd3
    } mode_e;

    localparam logic [3:0] BLINK_NONE = 4'b0000;
    localparam logic [3:0] BLINK_HOUR = 4'b1100;
    localparam logic [3:0] BLINK_MIN  = 4'b0011;
    localparam logic [3:0] BLINK_SEC  = 4'b1111;

    typedef struct packed {
        logic inc_hour;
        logic inc_min;
        logic clr_sec;
    } strobe_t;

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_RUN:      return MODE_SET_HOUR;
            MODE_SET_HOUR: return MODE_SET_MIN;
            MODE_SET_MIN:  return MODE_SET_SEC;
            default:       return MODE_RUN;
        endcase
    endfunction

    // Digits blanked during the "off" half of the blink for each mode.
    function automatic logic [3:0] blink_pattern(input mode_e m);
        case (m)
            MODE_SET_HOUR: return BLINK_HOUR;
            MODE_SET_MIN:  return BLINK_MIN;
            MODE_SET_SEC:  return BLINK_SEC;
            default:       return BLINK_NONE;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioning: 2-flop synchronizer, stable-count debouncer and
// a one-cycle pulse on the rising edge of the debounced level.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int unsigned     CNT_W   = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(DEB_CYCLES);

    logic [1:0]       sync_q;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Level flips only after the synchronized input disagrees for DEB_CYCLES+1 samples.
    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LIM) begin
                level_d = sync_q[1];
                rise_d  = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn};
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: mode FSM, field increment/clear strobes with
// auto-repeat, counter run-enable and display blink mask.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned DEB_CYCLES   = 16,
    parameter int unsigned REPEAT_DELAY = 32,
    parameter int unsigned REPEAT_RATE  = 8,
    parameter int unsigned BLINK_HALF   = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       run_en,
    output logic       inc_hour,
    output logic       inc_min,
    output logic       clr_sec,
    output logic [1:0] mode,
    output logic [3:0] blink_mask
);

    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
    localparam int unsigned BLINK_W = $clog2(BLINK_HALF + 1);

    localparam logic [REP_W-1:0]   DELAY_LIM = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0]   RATE_LIM  = REP_W'(REPEAT_RATE - 1);
    localparam logic [BLINK_W-1:0] BLINK_LIM = BLINK_W'(BLINK_HALF - 1);

    logic mode_lvl, mode_rise, mode_press;
    logic inc_lvl, inc_rise;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_mode),
        .level (mode_lvl),
        .rise  (mode_rise)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_inc),
        .level (inc_lvl),
        .rise  (inc_rise)
    );

    assign mode_press = mode_rise & mode_lvl;

    mode_e              state_q, state_d;
    strobe_t            strobe_q, strobe_d;
    logic               run_en_q, run_en_d;
    logic [3:0]         mask_q, mask_d;
    logic               rep_act_q, rep_act_d;
    logic               rep_fast_q, rep_fast_d;
    logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
    logic               phase_q, phase_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;

    always_comb begin
        state_d     = state_q;
        strobe_d    = '0;
        rep_act_d   = rep_act_q;
        rep_fast_d  = rep_fast_q;
        rep_cnt_d   = rep_cnt_q;
        phase_d     = phase_q;
        blink_cnt_d = blink_cnt_q;

        // Mode press beats a coincident inc press and cancels any auto-repeat.
        if (mode_press) begin
            state_d   = next_mode(state_q);
            rep_act_d = 1'b0;
        end else if (inc_rise) begin
            rep_cnt_d  = '0;
            rep_fast_d = 1'b0;
            unique case (state_q)
                MODE_SET_HOUR: begin
                    strobe_d.inc_hour = 1'b1;
                    rep_act_d         = 1'b1;
                end
                MODE_SET_MIN: begin
                    strobe_d.inc_min = 1'b1;
                    rep_act_d        = 1'b1;
                end
                MODE_SET_SEC: begin
                    strobe_d.clr_sec = 1'b1;
                    rep_act_d        = 1'b0;
                end
                default: ;
            endcase
        end else if (rep_act_q) begin
            if (!inc_lvl) begin
                rep_act_d = 1'b0;
            end else if (rep_cnt_q == (rep_fast_q ? RATE_LIM : DELAY_LIM)) begin
                rep_cnt_d  = '0;
                rep_fast_d = 1'b1;
                if (state_q == MODE_SET_HOUR) strobe_d.inc_hour = 1'b1;
                else                          strobe_d.inc_min  = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + REP_W'(1);
            end
        end

        // Digits are forced visible on entry to a state and on every strobe.
        if (state_d == MODE_RUN || state_d != state_q || (|strobe_d)) begin
            phase_d     = 1'b0;
            blink_cnt_d = '0;
        end else if (blink_cnt_q == BLINK_LIM) begin
            phase_d     = ~phase_q;
            blink_cnt_d = '0;
        end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        end

        run_en_d = (state_d == MODE_RUN);
        mask_d   = phase_d ? blink_pattern(state_d) : BLINK_NONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= MODE_RUN;
            strobe_q    <= '0;
            run_en_q    <= 1'b1;
            mask_q      <= BLINK_NONE;
            rep_act_q   <= 1'b0;
            rep_fast_q  <= 1'b0;
            rep_cnt_q   <= '0;
            phase_q     <= 1'b0;
            blink_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            strobe_q    <= strobe_d;
            run_en_q    <= run_en_d;
            mask_q      <= mask_d;
            rep_act_q   <= rep_act_d;
            rep_fast_q  <= rep_fast_d;
            rep_cnt_q   <= rep_cnt_d;
            phase_q     <= phase_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign mode       = state_q;
    assign run_en     = run_en_q;
    assign inc_hour   = strobe_q.inc_hour;
    assign inc_min    = strobe_q.inc_min;
    assign clr_sec    = strobe_q.clr_sec;
    assign blink_mask = mask_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with short debounce/repeat/blink timings.
module tb_clock_set_ctrl;

    localparam int unsigned DEB = 4;
    localparam int unsigned RD  = 20;
    localparam int unsigned RR  = 5;
    localparam int unsigned BH  = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_mode;
    logic       btn_inc;
    logic       run_en;
    logic       inc_hour;
    logic       inc_min;
    logic       clr_sec;
    logic [1:0] mode;
    logic [3:0] blink_mask;

    always #5 clk = ~clk;

    clock_set_ctrl #(
        .DEB_CYCLES   (DEB),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR),
        .BLINK_HALF   (BH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .run_en     (run_en),
        .inc_hour   (inc_hour),
        .inc_min    (inc_min),
        .clr_sec    (clr_sec),
        .mode       (mode),
        .blink_mask (blink_mask)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_hour, n_min, n_sec, n_multi;
    int min_t, sec_t;
    int hour_t[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: sample #1 after the edge and log any strobes.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (inc_hour) begin n_hour++; hour_t.push_back(cyc); end
        if (inc_min)  begin n_min++;  min_t = cyc; end
        if (clr_sec)  begin n_sec++;  sec_t = cyc; end
        if (int'(inc_hour) + int'(inc_min) + int'(clr_sec) > 1) n_multi++;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic clear_counts();
        n_hour = 0; n_min = 0; n_sec = 0;
        min_t = -1; sec_t = -1;
        hour_t.delete();
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        steps(10);
        btn_mode = 1'b0;
        steps(12);
    endtask

    initial begin
        int p;
        int bad;
        int mask_bad;
        logic [3:0] exp_mask;
        logic [1:0] prev_m, next_m;
        int offs[7];

        offs = '{8, 28, 33, 38, 43, 48, 53};
        n_multi = 0;
        clear_counts();
        rst_n = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
        steps(3);
        check("rst_mode",    32'(mode), 32'd0);
        check("rst_run_en",  32'(run_en), 32'd1);
        check("rst_mask",    32'(blink_mask), 32'd0);
        check("rst_strobes", 32'({inc_hour, inc_min, clr_sec}), 32'd0);

        rst_n = 1'b1;
        bad = 0;
        repeat (50) begin
            step();
            if (mode != 2'd0 || !run_en || blink_mask != 4'd0) bad++;
        end
        check("idle_state",   32'(bad), 32'd0);
        check("idle_strobes", 32'(n_hour + n_min + n_sec), 32'd0);

        // Four mode presses cycle through every state back to RUN.
        for (int i = 0; i < 4; i++) begin
            prev_m = 2'(i);
            next_m = 2'((i + 1) % 4);
            btn_mode = 1'b1;
            steps(7);
            check("mode_hold", 32'(mode), 32'(prev_m));
            step();
            check("mode_chg",   32'(mode), 32'(next_m));
            check("mode_runen", 32'(run_en), 32'(next_m == 2'd0));
            steps(2);
            btn_mode = 1'b0;
            steps(12);
        end

        clear_counts();
        btn_inc = 1'b1; steps(10); btn_inc = 1'b0; steps(12);
        check("run_inc_ignored", 32'(n_hour + n_min + n_sec), 32'd0);
        check("run_inc_mode",    32'(mode), 32'd0);

        press_mode();
        press_mode();
        check("to_set_min", 32'(mode), 32'd2);

        clear_counts();
        btn_inc = 1'b1; steps(3); btn_inc = 1'b0; steps(10);
        check("glitch_no_evt", 32'(n_min), 32'd0);
        p = cyc;
        btn_inc = 1'b1; steps(10); btn_inc = 1'b0; steps(15);
        check("min_count",   32'(n_min), 32'd1);
        check("min_latency", 32'(min_t - p), 32'd8);
        check("min_no_hour", 32'(n_hour), 32'd0);

        press_mode();
        check("to_set_sec", 32'(mode), 32'd3);
        check("sec_run_en", 32'(run_en), 32'd0);

        // Held inc in SET_SEC: a single clear, then blink restarts from visible.
        clear_counts();
        mask_bad = 0;
        p = cyc;
        btn_inc = 1'b1;
        for (int i = 1; i <= 75; i++) begin
            if (i == 61) btn_inc = 1'b0;
            step();
            if (cyc >= p + 8) begin
                exp_mask = (((cyc - (p + 8)) / 8) % 2 == 1) ? 4'hF : 4'h0;
                if (blink_mask != exp_mask) mask_bad++;
            end
            if (cyc == p + 8)  check("sec_mask_after_strobe", 32'(blink_mask), 32'h0);
            if (cyc == p + 16) check("sec_mask_blank",        32'(blink_mask), 32'hF);
        end
        check("sec_count",   32'(n_sec), 32'd1);
        check("sec_latency", 32'(sec_t - p), 32'd8);
        check("sec_blink",   32'(mask_bad), 32'd0);

        press_mode();
        check("back_to_run", 32'(mode), 32'd0);
        press_mode();
        check("to_set_hour", 32'(mode), 32'd1);

        // Held inc in SET_HOUR: first strobe, delay, then fixed-rate repeats.
        clear_counts();
        p = cyc;
        btn_inc = 1'b1; steps(50); btn_inc = 1'b0; steps(15);
        check("hour_count", 32'(n_hour), 32'd7);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("hour_t%0d", i), 32'(hour_t[i] - p), 32'(offs[i]));
        end
        check("hour_no_min", 32'(n_min), 32'd0);

        // Coincident presses: mode wins and the held inc never strobes.
        clear_counts();
        btn_mode = 1'b1; btn_inc = 1'b1;
        steps(7);
        check("simul_hold", 32'(mode), 32'd1);
        step();
        check("simul_mode", 32'(mode), 32'd2);
        steps(30);
        check("simul_no_strobe", 32'(n_hour + n_min + n_sec), 32'd0);

        rst_n = 1'b0;
        #1;
        check("midrst_mode",    32'(mode), 32'd0);
        check("midrst_run_en",  32'(run_en), 32'd1);
        check("midrst_mask",    32'(blink_mask), 32'd0);
        check("midrst_strobes", 32'({inc_hour, inc_min, clr_sec}), 32'd0);
        steps(2);

        // Buttons still held after reset count as a fresh press.
        rst_n = 1'b1;
        clear_counts();
        steps(7);
        check("post_rst_hold", 32'(mode), 32'd0);
        step();
        check("post_rst_press",   32'(mode), 32'd1);
        check("post_rst_no_strb", 32'(n_hour + n_min + n_sec), 32'd0);
        btn_mode = 1'b0; btn_inc = 1'b0;
        steps(12);
        check("one_hot_strobes", 32'(n_multi), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
